// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file -- 32 x DATA_WIDTH register file, one write port, two read ports.
//
// Storage is one flip-flop word per register, written through a 5:32 decoder.
// Each read port is a column of mux32_1 cells, one per data bit, steered by
// the read register number. Register ZERO_REG has no storage at all and
// always reads as zero.
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a write in progress is forwarded to any
//                      read port selecting the same (non-zero) register in
//                      the same cycle. When undefined, a read-during-write
//                      returns the old value until the clock edge.
//
// Ports:
//   clk            rising-edge clock for all storage
//   reset          synchronous, active-high; clears every register
//   RegWrite       write enable, sampled at the rising edge
//   WriteRegister  destination register index
//   WriteData      data written to WriteRegister
//   ReadRegister1  read port 1 register index
//   ReadRegister2  read port 2 register index
//   ReadData1      contents of ReadRegister1 (combinational)
//   ReadData2      contents of ReadRegister2 (combinational)
// ---------------------------------------------------------------------------
`timescale 1ps/1ps

// One-bit 32:1 selector used as the building block of each read column.
module mux32_1 (
    input  logic [31:0] d,
    input  logic [4:0]  sel,
    output logic        y
);
    assign y = d[sel];
endmodule

module reg_file #(
    parameter int DATA_WIDTH = 64,
    parameter int ZERO_REG   = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [4:0]            WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [4:0]            ReadRegister1,
    input  logic [4:0]            ReadRegister2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);

    // Current contents of every register as seen by the read muxes.
    wire [DATA_WIDTH-1:0] word [32];

    // Raw outputs of the mux32_1 columns, before any forwarding.
    wire [DATA_WIDTH-1:0] mux_out1;
    wire [DATA_WIDTH-1:0] mux_out2;

    // -----------------------------------------------------------------------
    // Storage and write decoder. Each register owns its decoder output; the
    // zero register gets neither an enable nor flops, so a write aimed at it
    // simply has nowhere to land and it reads zero even before any reset.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_reg
            if (gi == ZERO_REG) begin : g_zero
                assign word[gi] = '0;
            end else begin : g_word
                logic                  write_en;
                logic [DATA_WIDTH-1:0] word_reg;

                // One-hot when RegWrite=1, all-zero when RegWrite=0.
                assign write_en = RegWrite && (WriteRegister == 5'(gi));

                // Reset wins over a simultaneous write.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        word_reg <= '0;
                    end else if (write_en) begin
                        word_reg <= WriteData;
                    end
                end

                assign word[gi] = word_reg;
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Read columns: for every data bit, gather that bit from all 32 words and
    // pick one with a mux32_1 per port.
    // -----------------------------------------------------------------------
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
            logic [31:0] column;

            always_comb begin
                column = '0;
                for (int j = 0; j < 32; j++) begin
                    column[j] = word[j][gi];
                end
            end

            mux32_1 u_mux1 (
                .d   (column),
                .sel (ReadRegister1),
                .y   (mux_out1[gi])
            );

            mux32_1 u_mux2 (
                .d   (column),
                .sel (ReadRegister2),
                .y   (mux_out2[gi])
            );
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    // -----------------------------------------------------------------------
    // Write-through forwarding: a live write (not masked by reset, not aimed
    // at the zero register) overrides the stored value on a matching port.
    // -----------------------------------------------------------------------
    logic write_live;
    logic fwd1;
    logic fwd2;

    assign write_live = RegWrite && !reset && (WriteRegister != 5'(ZERO_REG));
    assign fwd1       = write_live && (WriteRegister == ReadRegister1);
    assign fwd2       = write_live && (WriteRegister == ReadRegister2);

    assign ReadData1 = fwd1 ? WriteData : mux_out1;
    assign ReadData2 = fwd2 ? WriteData : mux_out2;
`else
    // Without forwarding a read-during-write sees the old value until the edge.
    assign ReadData1 = mux_out1;
    assign ReadData2 = mux_out2;
`endif

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file -- self-checking bench for reg_file.
//
// Inputs change 1 ps after a rising edge and outputs are sampled on the
// following falling edge, 10000 ps later. Every sampled cycle is compared
// against a behavioural model (a plain array of register values); table rows
// and hand-written sequences add fixed expected constants on top.
// ---------------------------------------------------------------------------
`timescale 1ps/1ps

module tb_reg_file;

    localparam int DW = 64;
    localparam int ZR = 31;

    logic          clk;
    logic          reset;
    logic          RegWrite;
    logic [4:0]    WriteRegister;
    logic [DW-1:0] WriteData;
    logic [4:0]    ReadRegister1;
    logic [4:0]    ReadRegister2;
    logic [DW-1:0] ReadData1;
    logic [DW-1:0] ReadData2;

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural model: what each architectural register holds right now.
    logic [DW-1:0] model [32];

    reg_file #(.DATA_WIDTH(DW), .ZERO_REG(ZR)) dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    initial clk = 1'b0;
    always #10000 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Value a read port should show this cycle, from the model plus the
    // inputs presented in the same cycle.
    function automatic logic [DW-1:0] model_read(input logic [4:0] idx, input logic rst,
                                                 input logic we, input logic [4:0] wr,
                                                 input logic [DW-1:0] wd);
        logic [DW-1:0] v;
        v = (idx == 5'(ZR)) ? '0 : model[idx];
`ifdef REGFILE_BYPASS_EN
        if (we && !rst && wr != 5'(ZR) && wr == idx) v = wd;
`endif
        return v;
    endfunction

    // One clock cycle: drive inputs after the edge, sample at the falling
    // edge, compare with the model, then advance the model to what the next
    // rising edge will commit.
    task automatic cycle(input logic rst, input logic we, input logic [4:0] wr,
                         input logic [DW-1:0] wd, input logic [4:0] a, input logic [4:0] b,
                         input bit chk, output logic [DW-1:0] d1, output logic [DW-1:0] d2);
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        @(posedge clk);
        #1;
        reset = rst; RegWrite = we; WriteRegister = wr; WriteData = wd;
        ReadRegister1 = a; ReadRegister2 = b;
        @(negedge clk);
        d1 = ReadData1;
        d2 = ReadData2;
        e1 = model_read(a, rst, we, wr, wd);
        e2 = model_read(b, rst, we, wr, wd);
        if (chk) begin
            check($sformatf("model port1 r%0d", a), d1, e1);
            check($sformatf("model port2 r%0d", b), d2, e2);
            $display("[TB] rst=%0b we=%0b wr=%0d wd=%h r1=%0d:%h r2=%0d:%h",
                     rst, we, wr, wd, a, d1, b, d2);
        end
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (we && wr != 5'(ZR)) begin
            model[wr] = wd;
        end
    endtask

    typedef struct {
        logic          rst;
        logic          we;
        logic [4:0]    wr;
        logic [DW-1:0] wd;
        logic [4:0]    r1;
        logic [4:0]    r2;
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp2;
    } vec_t;

    localparam logic [DW-1:0] A5   = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [DW-1:0] R30  = 64'h3030_3030_0000_3030;
    localparam logic [DW-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [DW-1:0] WALK = 64'h0123_4567_89AB_0000;

    vec_t vecs [13];

    initial begin
        logic [DW-1:0] d1, d2;
        logic [4:0] ra, rb, wr;
        logic rst, we;

        reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        // Outputs are undefined until the first reset edge; do not check it.
        cycle(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd30, 1'b0, d1, d2);
        // Held in reset: everything reads zero.
        cycle(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd30, 1'b1, d1, d2);

        // Rows never read the register being written, so the expected
        // constants hold with or without forwarding.
        vecs[0]  = '{1'b0, 1'b0, 5'd0,  64'h0,         5'd0,  5'd30, 64'h0, 64'h0};
        vecs[1]  = '{1'b0, 1'b1, 5'd5,  A5,            5'd0,  5'd30, 64'h0, 64'h0};
        vecs[2]  = '{1'b0, 1'b1, 5'd30, R30,           5'd5,  5'd0,  A5,    64'h0};
        vecs[3]  = '{1'b0, 1'b1, 5'd31, ONES,          5'd30, 5'd5,  R30,   A5};
        vecs[4]  = '{1'b0, 1'b0, 5'd5,  64'h1,         5'd31, 5'd31, 64'h0, 64'h0};
        vecs[5]  = '{1'b0, 1'b0, 5'd5,  64'h1,         5'd5,  5'd30, A5,    R30};
        vecs[6]  = '{1'b0, 1'b0, 5'd5,  64'h1,         5'd5,  5'd5,  A5,    A5};
        vecs[7]  = '{1'b0, 1'b0, 5'd5,  64'h1,         5'd5,  5'd31, A5,    64'h0};
        vecs[8]  = '{1'b0, 1'b1, 5'd0,  64'h77,        5'd5,  5'd30, A5,    R30};
        vecs[9]  = '{1'b1, 1'b1, 5'd7,  64'hDEAD_BEEF, 5'd0,  5'd7,  64'h77, 64'h0};
        vecs[10] = '{1'b0, 1'b0, 5'd7,  64'h0,         5'd7,  5'd0,  64'h0, 64'h0};
        vecs[11] = '{1'b0, 1'b0, 5'd0,  64'h0,         5'd5,  5'd30, 64'h0, 64'h0};
        vecs[12] = '{1'b0, 1'b0, 5'd0,  64'h0,         5'd31, 5'd7,  64'h0, 64'h0};

        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].rst, vecs[i].we, vecs[i].wr, vecs[i].wd,
                  vecs[i].r1, vecs[i].r2, 1'b1, d1, d2);
            check($sformatf("table row %0d port1", i), d1, vecs[i].exp1);
            check($sformatf("table row %0d port2", i), d2, vecs[i].exp2);
        end

        // Walk-write: fill 0..30 with distinct patterns, then read (k, 30-k).
        for (int k = 0; k <= 30; k++) begin
            cycle(1'b0, 1'b1, 5'(k), WALK + 64'(k), 5'd31, 5'd31, 1'b1, d1, d2);
        end
        for (int k = 0; k <= 30; k++) begin
            cycle(1'b0, 1'b0, 5'd0, '0, 5'(k), 5'(30 - k), 1'b1, d1, d2);
            check($sformatf("walk port1 r%0d", k), d1, WALK + 64'(k));
            check($sformatf("walk port2 r%0d", 30 - k), d2, WALK + 64'(30 - k));
        end

        // Zero register write leaves register 30 untouched.
        cycle(1'b0, 1'b1, 5'd31, ONES, 5'd30, 5'd30, 1'b1, d1, d2);
        cycle(1'b0, 1'b0, 5'd0, '0, 5'd31, 5'd30, 1'b1, d1, d2);
        check("zero reg read", d1, 64'h0);
        check("r30 after zero write", d2, WALK + 64'd30);

        // Read-during-write on register 9, both ports.
        cycle(1'b0, 1'b1, 5'd9, 64'h11, 5'd0, 5'd0, 1'b1, d1, d2);
        cycle(1'b0, 1'b1, 5'd9, 64'h22, 5'd9, 5'd9, 1'b1, d1, d2);
`ifdef REGFILE_BYPASS_EN
        check("rdw before edge port1", d1, 64'h22);
        check("rdw before edge port2", d2, 64'h22);
`else
        check("rdw before edge port1", d1, 64'h11);
        check("rdw before edge port2", d2, 64'h11);
`endif
        cycle(1'b0, 1'b0, 5'd9, 64'h33, 5'd9, 5'd9, 1'b1, d1, d2);
        check("rdw after edge port1", d1, 64'h22);
        check("rdw after edge port2", d2, 64'h22);

        // Randomized traffic against the model, with occasional resets and
        // a bias toward reading the write target.
        for (int n = 0; n < 300; n++) begin
            rst = ($urandom_range(0, 29) == 0);
            we  = ($urandom_range(0, 2) != 0);
            wr  = 5'($urandom_range(0, 31));
            ra  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            rb  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            cycle(rst, we, wr, {$urandom, $urandom}, ra, rb, 1'b1, d1, d2);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
